baud_rate_generator: RTL and testbench

Parametrised successor to the fixed-divider UART baud controller. Generates a 16x (configurable) oversampling strobe for the receiver and a 1x bit strobe for the transmitter from a single system clock. Uses a fractional phase accumulator, so the long-term rate error is bounded by one clock per tick at any CLK_HZ. Sits between the system clock domain and the UART TX/RX blocks; one instance serves both.

---
 rtl/baud_pkg.sv | 45 ++++
 rtl/baud_rate_generator_if.sv | 33 +++
 rtl/baud_rate_generator_inc_rom.sv | 37 +++
 rtl/baud_rate_generator.sv | 120 ++++++++++++
 tb/tb_baud_rate_generator.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/baud_pkg.sv
// ----------------------------------------------------------------------------
// baud_pkg
// Shared constants for the UART baud rate generator and its users (TX, RX,
// bench): the supported baud rate list, default oversampling/accumulator
// widths, the rate code enumeration and the phase-increment function.
// ----------------------------------------------------------------------------
package baud_pkg;

   localparam int unsigned     NUM_RATES      = 32'd8;
   localparam int unsigned     DEF_OVERSAMPLE = 32'd16;
   localparam int unsigned     DEF_ACC_W      = 32'd24;
   localparam int unsigned     DEF_CNT_W      = 32'd6;
   localparam longint unsigned DEF_CLK_HZ     = 64'd100000000;

   // Rate code -> baud rate; entry 0 is the rightmost word.
   localparam logic [NUM_RATES-1:0][31:0] BAUD_RATES = {
      32'd115200, 32'd57600, 32'd38400, 32'd19200,
      32'd9600,   32'd4800,  32'd1200,  32'd300
   };

   typedef enum logic [2:0] {
      BAUD_300    = 3'b000,
      BAUD_1200   = 3'b001,
      BAUD_4800   = 3'b010,
      BAUD_9600   = 3'b011,
      BAUD_19200  = 3'b100,
      BAUD_38400  = 3'b101,
      BAUD_57600  = 3'b110,
      BAUD_115200 = 3'b111
   } baud_sel_e;

   // round(baud * oversample * 2^acc_w / clk_hz); the 64-bit product holds
   // every table entry for acc_w up to 32 and oversample up to 64.
   function automatic longint unsigned calc_inc(
      input longint unsigned baud,
      input longint unsigned oversample,
      input int unsigned     acc_w,
      input longint unsigned clk_hz
   );
      longint unsigned num;
      num = (baud * oversample) << acc_w;
      return (num + (clk_hz >> 1)) / clk_hz;
   endfunction

endpackage

// File: rtl/baud_rate_generator_if.sv
// ----------------------------------------------------------------------------
// baud_rate_generator_if
// Configuration and strobe bundle of the baud rate generator.
//   en            run enable
//   baud_select   rate code (see baud_pkg::baud_sel_e)
//   inc_override  custom phase increment, used when ovr_mode = 1
//   ovr_mode      selects inc_override instead of the rate table
//   sample_ENABLE one-cycle oversample strobe (RX)
//   tx_ENABLE     one-cycle bit strobe (TX)
//   cfg_busy      restart cycle after a configuration change
// master = configuring side (UART / bench), slave = the generator.
// ----------------------------------------------------------------------------
interface baud_rate_generator_if #(
   parameter int unsigned ACC_W = 32'd24
);
   logic             en;
   logic [2:0]       baud_select;
   logic [ACC_W-1:0] inc_override;
   logic             ovr_mode;
   logic             sample_ENABLE;
   logic             tx_ENABLE;
   logic             cfg_busy;

   modport master (
      output en, baud_select, inc_override, ovr_mode,
      input  sample_ENABLE, tx_ENABLE, cfg_busy
   );

   modport slave (
      input  en, baud_select, inc_override, ovr_mode,
      output sample_ENABLE, tx_ENABLE, cfg_busy
   );
endinterface

// File: rtl/baud_rate_generator_inc_rom.sv
// ----------------------------------------------------------------------------
// baud_inc_rom
// Combinational rate code -> phase increment lookup. The table is computed at
// elaboration from CLK_HZ, OVERSAMPLE and ACC_W.
//   i_baud_select  rate code
//   o_inc          phase increment for that rate
// ----------------------------------------------------------------------------
module baud_inc_rom
   import baud_pkg::*;
#(
   parameter longint unsigned CLK_HZ     = DEF_CLK_HZ,
   parameter int unsigned     OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned     ACC_W      = DEF_ACC_W
)(
   input  logic [2:0]       i_baud_select,
   output logic [ACC_W-1:0] o_inc
);

   typedef logic [ACC_W-1:0]           inc_t;
   typedef inc_t [NUM_RATES-1:0]       table_t;

   function automatic table_t build_table();
      table_t t;
      for (int unsigned k = 32'd0; k < NUM_RATES; k++) begin
         t[k] = inc_t'(calc_inc(64'(BAUD_RATES[k]), 64'(OVERSAMPLE), ACC_W, CLK_HZ));
      end
      return t;
   endfunction

   localparam table_t INC_TABLE = build_table();

   // Table lookup; all eight codes are populated.
   always_comb begin
      o_inc = INC_TABLE[i_baud_select];
   end

endmodule

// File: rtl/baud_rate_generator.sv
// ----------------------------------------------------------------------------
// baud_rate_generator
// Fractional phase-accumulator baud generator. Each enabled clock adds the
// selected increment to an ACC_W-bit accumulator; the carry out becomes the
// oversample strobe, and every OVERSAMPLE-th carry also raises the bit strobe.
// A configuration change restarts the accumulator and counter for one cycle.
//   i_clk    system clock, rising edge
//   i_reset  asynchronous active-high reset
//   bus      configuration inputs and strobe outputs (slave modport)
// ----------------------------------------------------------------------------
module baud_rate_generator
   import baud_pkg::*;
#(
   parameter longint unsigned CLK_HZ     = DEF_CLK_HZ,
   parameter int unsigned     OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int unsigned     ACC_W      = DEF_ACC_W,
   parameter int unsigned     CNT_W      = DEF_CNT_W
)(
   input  logic                  i_clk,
   input  logic                  i_reset,
   baud_rate_generator_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 32'd1);

   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_sel_q;
   logic             r_mode_q;
   logic [ACC_W-1:0] r_ovr_q;
   logic             r_sample;
   logic             r_tx;
   logic             r_busy;

   logic [ACC_W-1:0] w_rom_inc;
   logic [ACC_W-1:0] w_inc;
   logic [ACC_W:0]   w_sum;
   logic             w_carry;
   logic             w_cfg_change;
   logic [ACC_W-1:0] w_acc_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_sample_nxt;
   logic             w_tx_nxt;
   logic             w_busy_nxt;

   baud_inc_rom #(
      .CLK_HZ     (CLK_HZ),
      .OVERSAMPLE (OVERSAMPLE),
      .ACC_W      (ACC_W)
   ) u_inc_rom (
      .i_baud_select (bus.baud_select),
      .o_inc         (w_rom_inc)
   );

   // Increment selection, accumulator sum and configuration-change detect.
   always_comb begin
      w_inc   = bus.ovr_mode ? bus.inc_override : w_rom_inc;
      w_sum   = {1'b0, r_acc} + {1'b0, w_inc};
      w_carry = w_sum[ACC_W];
      // The override value only matters while override mode is selected.
      w_cfg_change = ({bus.ovr_mode, bus.baud_select} != {r_mode_q, r_sel_q}) ||
                     (bus.ovr_mode && (bus.inc_override != r_ovr_q));
   end

   // Next-state for accumulator, counter and strobes.
   always_comb begin
      w_acc_nxt    = r_acc;
      w_cnt_nxt    = r_cnt;
      w_sample_nxt = 1'b0;
      w_tx_nxt     = 1'b0;
      w_busy_nxt   = 1'b0;
      if (!bus.en) begin
         w_acc_nxt = '0;
         w_cnt_nxt = '0;
      end else if (w_cfg_change) begin
         // Restart: any tick that would have fired this cycle is dropped.
         w_acc_nxt  = '0;
         w_cnt_nxt  = '0;
         w_busy_nxt = 1'b1;
      end else begin
         w_acc_nxt    = w_sum[ACC_W-1:0];
         w_sample_nxt = w_carry;
         w_tx_nxt     = w_carry && (r_cnt == CNT_LAST);
         if (w_carry) begin
            w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : (r_cnt + CNT_W'(1'b1));
         end else begin
            w_cnt_nxt = r_cnt;
         end
      end
   end

   // State registers; configuration copies always follow the inputs so that
   // toggling en alone never looks like a configuration change.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_acc    <= '0;
         r_cnt    <= '0;
         r_sel_q  <= 3'b000;
         r_mode_q <= 1'b0;
         r_ovr_q  <= '0;
         r_sample <= 1'b0;
         r_tx     <= 1'b0;
         r_busy   <= 1'b0;
      end else begin
         r_acc    <= w_acc_nxt;
         r_cnt    <= w_cnt_nxt;
         r_sel_q  <= bus.baud_select;
         r_mode_q <= bus.ovr_mode;
         r_ovr_q  <= bus.inc_override;
         r_sample <= w_sample_nxt;
         r_tx     <= w_tx_nxt;
         r_busy   <= w_busy_nxt;
      end
   end

   assign bus.sample_ENABLE = r_sample;
   assign bus.tx_ENABLE     = r_tx;
   assign bus.cfg_busy      = r_busy;

endmodule

// File: tb/tb_baud_rate_generator.sv
// ----------------------------------------------------------------------------
// tb_baud_rate_generator
// Directed bench for baud_rate_generator at CLK_HZ = 100 MHz, OVERSAMPLE = 16,
// ACC_W = 24. Expected tick intervals are ceil/floor of 2^24 / inc, worked out
// by hand from the increments 12885 (4800), 25770 (9600), 51540 (19200) and
// 309238 (115200).
// ----------------------------------------------------------------------------
module tb_baud_rate_generator;
   import baud_pkg::*;

   localparam int unsigned ACC_W = 32'd24;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;

   baud_rate_generator_if #(.ACC_W(ACC_W)) bus_if ();

   baud_rate_generator #(
      .CLK_HZ     (64'd100000000),
      .OVERSAMPLE (32'd16),
      .ACC_W      (ACC_W),
      .CNT_W      (32'd6)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle 1 ns past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Step until sample_ENABLE is seen; n = edges taken, -1 if budget expires.
   task automatic wait_sample(input int budget, output int n, output bit tx,
                              output bit busy_seen, output bit tx_alone);
      n = -1; tx = 1'b0; busy_seen = 1'b0; tx_alone = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         step();
         if (bus_if.cfg_busy) busy_seen = 1'b1;
         if (bus_if.tx_ENABLE && !bus_if.sample_ENABLE) tx_alone = 1'b1;
         if (bus_if.sample_ENABLE) begin
            n  = i;
            tx = bus_if.tx_ENABLE;
            return;
         end
      end
   endtask

   task automatic test_reset();
      bus_if.en           = 1'b1;
      bus_if.baud_select  = BAUD_4800;
      bus_if.ovr_mode     = 1'b0;
      bus_if.inc_override = 24'd0;
      rst = 1'b1;
      #20;
      n_vec++;
      if (bus_if.sample_ENABLE !== 1'b0 || bus_if.tx_ENABLE !== 1'b0 || bus_if.cfg_busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: got s=%b t=%b b=%b want 0 0 0",
                  bus_if.sample_ENABLE, bus_if.tx_ENABLE, bus_if.cfg_busy);
      end
      #2;
      rst = 1'b0;
   endtask

   task automatic test_rate_4800();
      int n; bit tx, busy, alone;
      step();
      n_vec++;
      if (bus_if.cfg_busy !== 1'b1 || bus_if.sample_ENABLE !== 1'b0) begin
         n_err++;
         $display("FAIL r4800_restart: got busy=%b s=%b want 1 0", bus_if.cfg_busy, bus_if.sample_ENABLE);
      end
      wait_sample(2000, n, tx, busy, alone);
      n_vec++;
      if (n !== 1303 || busy || tx) begin
         n_err++;
         $display("FAIL r4800_first: got n=%0d busy=%b tx=%b want 1303 0 0", n, busy, tx);
      end
      for (int k = 2; k <= 16; k++) begin
         wait_sample(2000, n, tx, busy, alone);
         n_vec++;
         if ((n != 1302 && n != 1303) || tx !== (k == 16) || alone) begin
            n_err++;
            $display("FAIL r4800_tick%0d: got n=%0d tx=%b want 1302/1303 tx=%b", k, n, tx, (k == 16));
         end
      end
   endtask

   task automatic test_rate_9600();
      int n, sum, txc; bit tx, busy, alone;
      bus_if.baud_select = BAUD_9600;
      step();
      n_vec++;
      if (bus_if.cfg_busy !== 1'b1) begin
         n_err++;
         $display("FAIL r9600_restart: got busy=%b want 1", bus_if.cfg_busy);
      end
      wait_sample(1000, n, tx, busy, alone);
      n_vec++;
      if (n !== 652) begin
         n_err++;
         $display("FAIL r9600_first: got %0d want 652", n);
      end
      sum = 0; txc = 0;
      for (int k = 2; k <= 33; k++) begin
         wait_sample(1000, n, tx, busy, alone);
         if (n < 0) sum = -100000;
         sum += n;
         if (tx) txc++;
      end
      n_vec++;
      if (sum != 20833 && sum != 20834) begin
         n_err++;
         $display("FAIL r9600_elapsed: got %0d want 20833/20834", sum);
      end
      n_vec++;
      if (txc !== 2) begin
         n_err++;
         $display("FAIL r9600_txcount: got %0d want 2", txc);
      end
   endtask

   task automatic test_rate_115200();
      int n, txc, bad; bit tx, busy, alone, any_alone;
      bus_if.baud_select = BAUD_115200;
      step();
      wait_sample(100, n, tx, busy, alone);
      n_vec++;
      if (n !== 55) begin
         n_err++;
         $display("FAIL r115200_first: got %0d want 55", n);
      end
      txc = 0; bad = 0; any_alone = alone;
      for (int k = 2; k <= 40; k++) begin
         wait_sample(100, n, tx, busy, alone);
         if (n != 54 && n != 55) bad++;
         if (tx) txc++;
         if (alone) any_alone = 1'b1;
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL r115200_intervals: got %0d bad intervals want 0", bad);
      end
      n_vec++;
      if (txc !== 2 || any_alone) begin
         n_err++;
         $display("FAIL r115200_tx: got count=%0d alone=%b want 2 0", txc, any_alone);
      end
   endtask

   task automatic test_cfg_change();
      int n; bit tx, busy, alone;
      bus_if.baud_select = BAUD_4800;
      step();
      wait_sample(2000, n, tx, busy, alone);
      for (int i = 0; i < 100; i++) step();
      bus_if.baud_select = BAUD_19200;
      step();
      n_vec++;
      if (bus_if.cfg_busy !== 1'b1 || bus_if.sample_ENABLE !== 1'b0 || bus_if.tx_ENABLE !== 1'b0) begin
         n_err++;
         $display("FAIL cfg_busy_cycle: got busy=%b s=%b t=%b want 1 0 0",
                  bus_if.cfg_busy, bus_if.sample_ENABLE, bus_if.tx_ENABLE);
      end
      wait_sample(400, n, tx, busy, alone);
      n_vec++;
      if (n !== 326 || busy) begin
         n_err++;
         $display("FAIL cfg_first_new: got n=%0d busy=%b want 326 0", n, busy);
      end
      wait_sample(400, n, tx, busy, alone);
      n_vec++;
      if (n != 325 && n != 326) begin
         n_err++;
         $display("FAIL cfg_second_new: got %0d want 325/326", n);
      end
   endtask

   task automatic test_override();
      int n, cyc, bad, txc, tx_at[2], sc, tc; bit tx, busy, alone;
      bus_if.ovr_mode     = 1'b1;
      bus_if.inc_override = 24'h100000;
      step();
      n_vec++;
      if (bus_if.cfg_busy !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_restart: got busy=%b want 1", bus_if.cfg_busy);
      end
      cyc = 0; bad = 0; txc = 0; tx_at[0] = 0; tx_at[1] = 0;
      for (int k = 1; k <= 40; k++) begin
         wait_sample(40, n, tx, busy, alone);
         if (n != 16) bad++;
         cyc += n;
         if (tx) begin
            if (txc < 2) tx_at[txc] = cyc;
            txc++;
         end
      end
      n_vec++;
      if (bad !== 0) begin
         n_err++;
         $display("FAIL ovr_period16: got %0d bad intervals want 0", bad);
      end
      n_vec++;
      if (txc !== 2 || tx_at[0] !== 256 || tx_at[1] !== 512) begin
         n_err++;
         $display("FAIL ovr_tx256: got count=%0d at %0d,%0d want 2 at 256,512", txc, tx_at[0], tx_at[1]);
      end
      bus_if.inc_override = 24'd0;
      step();
      n_vec++;
      if (bus_if.cfg_busy !== 1'b1) begin
         n_err++;
         $display("FAIL ovr_zero_restart: got busy=%b want 1", bus_if.cfg_busy);
      end
      sc = 0; tc = 0;
      for (int i = 0; i < 10000; i++) begin
         step();
         if (bus_if.sample_ENABLE) sc++;
         if (bus_if.tx_ENABLE) tc++;
      end
      n_vec++;
      if (sc !== 0 || tc !== 0) begin
         n_err++;
         $display("FAIL ovr_zero_silent: got s=%0d t=%0d want 0 0", sc, tc);
      end
   endtask

   task automatic test_enable_reset();
      int n, hi; bit tx, busy, alone;
      bus_if.ovr_mode    = 1'b0;
      bus_if.baud_select = BAUD_4800;
      step();
      wait_sample(2000, n, tx, busy, alone);
      n_vec++;
      if (n !== 1303) begin
         n_err++;
         $display("FAIL en_pre_first: got %0d want 1303", n);
      end
      bus_if.en = 1'b0;
      hi = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus_if.sample_ENABLE || bus_if.tx_ENABLE || bus_if.cfg_busy) hi++;
      end
      n_vec++;
      if (hi !== 0) begin
         n_err++;
         $display("FAIL en_low_quiet: got %0d active cycles want 0", hi);
      end
      bus_if.en = 1'b1;
      wait_sample(2000, n, tx, busy, alone);
      n_vec++;
      if (n !== 1303 || busy) begin
         n_err++;
         $display("FAIL en_restart: got n=%0d busy=%b want 1303 0", n, busy);
      end
      // sample_ENABLE is high now; pulse reset between clock edges.
      #2;
      rst = 1'b1;
      #1;
      n_vec++;
      if (bus_if.sample_ENABLE !== 1'b0 || bus_if.tx_ENABLE !== 1'b0 || bus_if.cfg_busy !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset_clear: got s=%b t=%b b=%b want 0 0 0",
                  bus_if.sample_ENABLE, bus_if.tx_ENABLE, bus_if.cfg_busy);
      end
      #2;
      rst = 1'b0;
      step();
      n_vec++;
      if (bus_if.cfg_busy !== 1'b1) begin
         n_err++;
         $display("FAIL post_reset_restart: got busy=%b want 1", bus_if.cfg_busy);
      end
      wait_sample(2000, n, tx, busy, alone);
      n_vec++;
      if (n !== 1303) begin
         n_err++;
         $display("FAIL post_reset_first: got %0d want 1303", n);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      test_reset();
      test_rate_4800();
      test_rate_9600();
      test_rate_115200();
      test_cfg_change();
      test_override();
      test_enable_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
